// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_if
// Description : Bus between the pipeline (master) and the register file.
// Revision    : 1.0
// ============================================================================
interface regfile_if;
  logic        we_i;
  logic [4:0]  sel_rd_i;
  logic [31:0] data_i;
  logic [4:0]  sel_rs1_i;
  logic [4:0]  sel_rs2_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic        busy_rs1_o;
  logic        busy_rs2_o;
  logic        err_o;

  modport master (
    output we_i, sel_rd_i, data_i, sel_rs1_i, sel_rs2_i, issue_i, issue_rd_i,
    input  rs1_data_o, rs2_data_o, issue_ready_o, busy_rs1_o, busy_rs2_o, err_o
  );

  modport slave (
    input  we_i, sel_rd_i, data_i, sel_rs1_i, sel_rs2_i, issue_i, issue_rd_i,
    output rs1_data_o, rs2_data_o, issue_ready_o, busy_rs1_o, busy_rs2_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : 31x32 register file with per-register pending-write
//               scoreboard. Optional write-to-read forwarding: REGFILE_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
module regfile (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  logic [31:0] rf_view   [0:31];
  logic [1:0]  pend_view [0:31];
  logic        wr_en;
  logic        issue_acc;
  logic        err_q;
  logic        err_d;
  logic        fwd1;
  logic        fwd2;

  // x0 is a constant zero with no pending count
  assign rf_view[0]   = '0;
  assign pend_view[0] = '0;

  assign wr_en             = bus.we_i && (bus.sel_rd_i != 5'd0);
  assign bus.issue_ready_o = !((bus.issue_rd_i != 5'd0) && (pend_view[bus.issue_rd_i] == 2'd3));
  assign issue_acc         = bus.issue_i && bus.issue_ready_o && (bus.issue_rd_i != 5'd0);

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_reg
      logic [31:0] rf_q;
      logic [1:0]  pend_q;
      logic [1:0]  pend_d;
      logic        wr_hit;
      logic        iss_hit;

      assign wr_hit  = wr_en && (bus.sel_rd_i == 5'(gi));
      assign iss_hit = issue_acc && (bus.issue_rd_i == 5'(gi));

      // A simultaneous issue and write to this register cancel out
      always_comb begin
        pend_d = pend_q;
        if (iss_hit && !wr_hit) begin
          pend_d = pend_q + 2'd1;
        end else if (wr_hit && !iss_hit && (pend_q != 2'd0)) begin
          pend_d = pend_q - 2'd1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rf_q   <= '0;
          pend_q <= '0;
        end else begin
          if (wr_hit) begin
            rf_q <= bus.data_i;
          end
          pend_q <= pend_d;
        end
      end

      assign rf_view[gi]   = rf_q;
      assign pend_view[gi] = pend_q;
    end
  endgenerate

  assign err_d = err_q || (wr_en && (pend_view[bus.sel_rd_i] == 2'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err_o = err_q;

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = rst_n && wr_en && (bus.sel_rd_i == bus.sel_rs1_i);
  assign fwd2 = rst_n && wr_en && (bus.sel_rd_i == bus.sel_rs2_i);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // A forwarded write retiring the last pending count frees the source now
  always_comb begin
    bus.rs1_data_o = fwd1 ? bus.data_i : rf_view[bus.sel_rs1_i];
    bus.rs2_data_o = fwd2 ? bus.data_i : rf_view[bus.sel_rs2_i];
    bus.busy_rs1_o = (bus.sel_rs1_i != 5'd0) && (pend_view[bus.sel_rs1_i] != 2'd0)
                     && !(fwd1 && (pend_view[bus.sel_rs1_i] == 2'd1));
    bus.busy_rs2_o = (bus.sel_rs2_i != 5'd0) && (pend_view[bus.sel_rs2_i] != 2'd0)
                     && !(fwd2 && (pend_view[bus.sel_rs2_i] == 2'd1));
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile
// Description : Directed and random checking of regfile against an array model.
// Revision    : 1.0
// ============================================================================
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmp_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_if bus ();

  regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Architectural model: register values, pending counts, sticky error
  logic [31:0] m_mem  [32];
  int          m_pend [32];
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit m_fwd(input logic [4:0] rs);
    return BYP && rst_n && bus.we_i && (bus.sel_rd_i != 0) && (bus.sel_rd_i == rs);
  endfunction

  function automatic logic [31:0] m_data(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (m_fwd(rs)) return bus.data_i;
    return m_mem[rs];
  endfunction

  function automatic bit m_busy(input logic [4:0] rs);
    if (rs == 0 || m_pend[rs] == 0) return 1'b0;
    if (m_fwd(rs) && m_pend[rs] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    return !(bus.issue_rd_i != 0 && m_pend[bus.issue_rd_i] == 3);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = 32'h0;
      m_pend[i] = 0;
    end
    m_err = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear();
    end else begin
      bit wr;
      bit acc;
      wr  = bus.we_i && (bus.sel_rd_i != 0);
      acc = bus.issue_i && m_ready() && (bus.issue_rd_i != 0);
      if (wr && m_pend[bus.sel_rd_i] == 0) m_err = 1'b1;
      if (!(wr && acc && bus.sel_rd_i == bus.issue_rd_i)) begin
        if (acc) m_pend[bus.issue_rd_i] = m_pend[bus.issue_rd_i] + 1;
        if (wr && m_pend[bus.sel_rd_i] > 0) m_pend[bus.sel_rd_i] = m_pend[bus.sel_rd_i] - 1;
      end
      if (wr) m_mem[bus.sel_rd_i] = bus.data_i;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_rs1_data", bus.rs1_data_o, m_data(bus.sel_rs1_i));
      chk("cmp_rs2_data", bus.rs2_data_o, m_data(bus.sel_rs2_i));
      chk("cmp_busy_rs1", 32'(bus.busy_rs1_o), 32'(m_busy(bus.sel_rs1_i)));
      chk("cmp_busy_rs2", 32'(bus.busy_rs2_o), 32'(m_busy(bus.sel_rs2_i)));
      chk("cmp_issue_ready", 32'(bus.issue_ready_o), 32'(m_ready()));
      chk("cmp_err", 32'(bus.err_o), 32'(m_err));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i = 1'b0;
    bus.issue_i = 1'b0;
  endtask

  initial begin
    bus.we_i = 1'b0;      bus.sel_rd_i = 5'd0;  bus.data_i = 32'h0;
    bus.sel_rs1_i = 5'd0; bus.sel_rs2_i = 5'd0;
    bus.issue_i = 1'b0;   bus.issue_rd_i = 5'd0;
    m_clear();
    cmp_en = 1'b1;

    // Reset state, with stimulus that must be ignored
    repeat (2) cyc();
    bus.issue_i = 1'b1; bus.issue_rd_i = 5'd2; bus.sel_rs1_i = 5'd2;
    #2;
    chk("rst_ready", 32'(bus.issue_ready_o), 32'd1);
    chk("rst_busy1", 32'(bus.busy_rs1_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    cyc();
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cyc();
      bus.sel_rs1_i = 5'(i);
      bus.sel_rs2_i = 5'(31 - i);
      #2;
      chk("init_rs1", bus.rs1_data_o, 32'h0);
      chk("init_rs2", bus.rs2_data_o, 32'h0);
    end
    chk("init_busy2", 32'(bus.busy_rs2_o), 32'd0);
    chk("init_err", 32'(bus.err_o), 32'd0);

    // x0 write is discarded and raises no error
    cyc(); bus.we_i = 1'b1; bus.sel_rd_i = 5'd0; bus.data_i = 32'h1234;
    cyc(); idle(); bus.sel_rs1_i = 5'd0;
    #2;
    chk("x0_read", bus.rs1_data_o, 32'h0);
    chk("x0_err", 32'(bus.err_o), 32'd0);

    // Same-cycle and next-cycle visibility of a write to x5
    cyc(); bus.issue_i = 1'b1; bus.issue_rd_i = 5'd5;
    cyc(); idle();
    bus.we_i = 1'b1; bus.sel_rd_i = 5'd5; bus.data_i = 32'hDEADBEEF;
    bus.sel_rs1_i = 5'd5; bus.sel_rs2_i = 5'd5;
    #2;
    chk("x5_same_cycle", bus.rs1_data_o, BYP ? 32'hDEADBEEF : 32'h0);
    cyc(); idle();
    #2;
    chk("x5_next_rs1", bus.rs1_data_o, 32'hDEADBEEF);
    chk("x5_next_rs2", bus.rs2_data_o, 32'hDEADBEEF);
    chk("x5_err", 32'(bus.err_o), 32'd0);

    // Saturate x7, check ready gating, then drain
    repeat (3) begin
      cyc(); bus.issue_i = 1'b1; bus.issue_rd_i = 5'd7;
    end
    cyc(); idle(); bus.issue_rd_i = 5'd7;
    #2;
    chk("x7_ready_full", 32'(bus.issue_ready_o), 32'd0);
    bus.issue_rd_i = 5'd8;
    #1;
    chk("x8_ready", 32'(bus.issue_ready_o), 32'd1);
    cyc(); bus.issue_i = 1'b1; bus.issue_rd_i = 5'd7;
    for (int k = 0; k < 3; k++) begin
      cyc(); idle();
      bus.sel_rs1_i = 5'd7;
      bus.we_i = 1'b1; bus.sel_rd_i = 5'd7; bus.data_i = 32'h70 + 32'(k);
      #2;
      chk("x7_busy_drain", 32'(bus.busy_rs1_o), (k == 2 && BYP) ? 32'd0 : 32'd1);
    end
    cyc(); idle(); bus.issue_rd_i = 5'd7;
    #2;
    chk("x7_busy_done", 32'(bus.busy_rs1_o), 32'd0);
    chk("x7_data", bus.rs1_data_o, 32'h72);
    chk("x7_ready_again", 32'(bus.issue_ready_o), 32'd1);

    // Issue and write to x9 in the same cycle keep the count at 1
    cyc(); bus.issue_i = 1'b1; bus.issue_rd_i = 5'd9;
    cyc(); bus.we_i = 1'b1; bus.sel_rd_i = 5'd9; bus.data_i = 32'h55; bus.sel_rs1_i = 5'd9;
    cyc(); idle();
    #2;
    chk("x9_busy_held", 32'(bus.busy_rs1_o), 32'd1);
    chk("x9_data", bus.rs1_data_o, 32'h55);
    cyc(); bus.we_i = 1'b1; bus.sel_rd_i = 5'd9; bus.data_i = 32'h56;
    cyc(); idle();
    #2;
    chk("x9_busy_clear", 32'(bus.busy_rs1_o), 32'd0);
    chk("x9_err", 32'(bus.err_o), 32'd0);

    // Unexpected write sets a sticky error; async reset clears everything
    cyc(); bus.we_i = 1'b1; bus.sel_rd_i = 5'd3; bus.data_i = 32'hA5; bus.sel_rs1_i = 5'd3;
    cyc(); idle();
    #2;
    chk("x3_err_set", 32'(bus.err_o), 32'd1);
    chk("x3_data", bus.rs1_data_o, 32'hA5);
    repeat (3) cyc();
    #2;
    chk("x3_err_sticky", 32'(bus.err_o), 32'd1);
    cyc(); bus.issue_i = 1'b1; bus.issue_rd_i = 5'd10;
    cyc(); idle();
    bus.we_i = 1'b1; bus.sel_rd_i = 5'd4; bus.data_i = 32'hCAFE; bus.sel_rs2_i = 5'd10;
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x3", bus.rs1_data_o, 32'h0);
    chk("mid_rst_err", 32'(bus.err_o), 32'd0);
    chk("mid_rst_busy2", 32'(bus.busy_rs2_o), 32'd0);
    cyc();
    idle(); rst_n = 1'b1; bus.sel_rs2_i = 5'd4;
    #2;
    chk("lost_write_x4", bus.rs2_data_o, 32'h0);

    // Random traffic on a narrow index range to force collisions
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst_n = ($urandom_range(0, 299) != 0);
      bus.we_i = $urandom_range(0, 1) == 1;
      bus.issue_i = $urandom_range(0, 1) == 1;
      bus.sel_rd_i = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      bus.issue_rd_i = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
      bus.sel_rs1_i = 5'($urandom_range(0, 7));
      bus.sel_rs2_i = 5'($urandom_range(0, 31));
      bus.data_i = $urandom;
    end
    cyc();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
